core_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It sequences instruction fetch, register read, execute, multi-cycle shift wait, load/store memory handshakes and writeback, using the latched instruction word. It sits beside the instruction decoder and emits the enable and strobe signals for the instruction register, register file, ALU/shifter, PC and memory port.

---
 rtl/core_ctrl_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32I core: fetch, register read, execute,
// shift/memory waits and writeback, with sticky halt causes and a retired-instruction counter.
module core_ctrl_fsm #(
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             mem_rbusy,
    input  logic             mem_wbusy,
    input  logic             alu_busy,
    output logic             mem_rstrb,
    output logic             mem_wstrb,
    output logic             mem_addr_sel,
    output logic             instr_we,
    output logic             rf_rd_en,
    output logic             alu_start,
    output logic             rf_we,
    output logic             pc_we,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        FETCH_INSTR = 3'd0,
        WAIT_INSTR  = 3'd1,
        FETCH_REGS  = 3'd2,
        EXECUTE     = 3'd3,
        WAIT_ALU    = 3'd4,
        WAIT_DATA   = 3'd5,
        WAIT_STORE  = 3'd6,
        HALT        = 3'd7
    } state_t;

    localparam logic [31:0] LIMIT_M1 = (WAIT_LIMIT == 0) ? 32'd0 : 32'(WAIT_LIMIT - 1);

    state_t            state_q, state_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;
    logic [31:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  instret_q;

    logic [4:0] opc;
    logic [2:0] func3;
    logic       rd_nz;
    logic       limit_hit;
    logic       unused_instr;

    assign opc          = instr[6:2];
    assign func3        = instr[14:12];
    assign rd_nz        = |instr[11:7];
    assign unused_instr = ^instr[31:15];
    // True on the cycle in which the counter would reach the limit.
    assign limit_hit    = (WAIT_LIMIT != 0) && (wait_cnt_q >= LIMIT_M1);

    always_comb begin
        mem_rstrb    = 1'b0;
        mem_wstrb    = 1'b0;
        mem_addr_sel = 1'b0;
        instr_we     = 1'b0;
        rf_rd_en     = 1'b0;
        alu_start    = 1'b0;
        rf_we        = 1'b0;
        pc_we        = 1'b0;
        halted       = 1'b0;
        state_d      = state_q;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        wait_cnt_d   = 32'd0;

        case (state_q)
            FETCH_INSTR: begin
                mem_rstrb = 1'b1;
                state_d   = WAIT_INSTR;
            end
            WAIT_INSTR: begin
                wait_cnt_d = wait_cnt_q + 32'd1;
                if (!mem_rbusy) begin
                    instr_we = 1'b1;
                    state_d  = FETCH_REGS;
                end else if (limit_hit) begin
                    timeout_d = 1'b1;
                    state_d   = HALT;
                end
            end
            FETCH_REGS: begin
                rf_rd_en = 1'b1;
                state_d  = EXECUTE;
            end
            EXECUTE: begin
                if (instr[1:0] != 2'b11) begin
                    illegal_d = 1'b1;
                    state_d   = HALT;
                end else begin
                    case (opc)
                        5'b01100, 5'b00100: begin
                            if (func3 == 3'b001 || func3 == 3'b101) begin
                                alu_start = 1'b1;
                                state_d   = WAIT_ALU;
                            end else begin
                                rf_we   = rd_nz;
                                pc_we   = 1'b1;
                                state_d = FETCH_INSTR;
                            end
                        end
                        5'b01101, 5'b00101, 5'b11011, 5'b11001: begin
                            rf_we   = rd_nz;
                            pc_we   = 1'b1;
                            state_d = FETCH_INSTR;
                        end
                        5'b11000: begin
                            pc_we   = 1'b1;
                            state_d = FETCH_INSTR;
                        end
                        5'b00000: begin
                            mem_rstrb    = 1'b1;
                            mem_addr_sel = 1'b1;
                            state_d      = WAIT_DATA;
                        end
                        5'b01000: begin
                            mem_wstrb    = 1'b1;
                            mem_addr_sel = 1'b1;
                            state_d      = WAIT_STORE;
                        end
                        5'b11100: state_d = HALT;
                        default: begin
                            illegal_d = 1'b1;
                            state_d   = HALT;
                        end
                    endcase
                end
            end
            WAIT_ALU: begin
                wait_cnt_d = wait_cnt_q + 32'd1;
                if (!alu_busy) begin
                    rf_we   = rd_nz;
                    pc_we   = 1'b1;
                    state_d = FETCH_INSTR;
                end else if (limit_hit) begin
                    timeout_d = 1'b1;
                    state_d   = HALT;
                end
            end
            WAIT_DATA: begin
                mem_addr_sel = 1'b1;
                wait_cnt_d   = wait_cnt_q + 32'd1;
                if (!mem_rbusy) begin
                    rf_we   = rd_nz;
                    pc_we   = 1'b1;
                    state_d = FETCH_INSTR;
                end else if (limit_hit) begin
                    timeout_d = 1'b1;
                    state_d   = HALT;
                end
            end
            WAIT_STORE: begin
                mem_addr_sel = 1'b1;
                wait_cnt_d   = wait_cnt_q + 32'd1;
                if (!mem_wbusy) begin
                    pc_we   = 1'b1;
                    state_d = FETCH_INSTR;
                end else if (limit_hit) begin
                    timeout_d = 1'b1;
                    state_d   = HALT;
                end
            end
            HALT: halted = 1'b1;
        endcase

        // Strobes must be quiet for the whole time reset is held, not just after the edge.
        if (reset) begin
            mem_rstrb    = 1'b0;
            mem_wstrb    = 1'b0;
            mem_addr_sel = 1'b0;
            instr_we     = 1'b0;
            rf_rd_en     = 1'b0;
            alu_start    = 1'b0;
            rf_we        = 1'b0;
            pc_we        = 1'b0;
            halted       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH_INSTR;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
            wait_cnt_q <= 32'd0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
            wait_cnt_q <= wait_cnt_d;
            if (pc_we) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm: one default instance and one with CNT_W=4, WAIT_LIMIT=4,
// sharing data inputs but with independent resets.
module tb_core_ctrl_fsm;

    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_SLLI  = 32'h00329293;
    localparam logic [31:0] I_LW    = 32'h00012203;
    localparam logic [31:0] I_SW    = 32'h00412023;
    localparam logic [31:0] I_ADDI0 = 32'h00100013;
    localparam logic [31:0] I_ZERO  = 32'h00000000;
    localparam logic [31:0] I_ECALL = 32'h00000073;

    // Strobe vector bits: rstrb wstrb asel iwe rfrd alust rfwe pcwe halted
    localparam logic [8:0] S_NONE = 9'h000;
    localparam logic [8:0] S_RSTB = 9'h100;
    localparam logic [8:0] S_WSTB = 9'h080;
    localparam logic [8:0] S_ASEL = 9'h040;
    localparam logic [8:0] S_IWE  = 9'h020;
    localparam logic [8:0] S_RFRD = 9'h010;
    localparam logic [8:0] S_ALST = 9'h008;
    localparam logic [8:0] S_RFWE = 9'h004;
    localparam logic [8:0] S_PCWE = 9'h002;
    localparam logic [8:0] S_HALT = 9'h001;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        rbusy = 1'b0;
    logic        wbusy = 1'b0;
    logic        abusy = 1'b0;

    logic a_rstrb, a_wstrb, a_asel, a_iwe, a_rfrd, a_alst, a_rfwe, a_pcwe, a_halted, a_illegal, a_timeout;
    logic b_rstrb, b_wstrb, b_asel, b_iwe, b_rfrd, b_alst, b_rfwe, b_pcwe, b_halted, b_illegal, b_timeout;
    logic [2:0]  a_state, b_state;
    logic [31:0] a_instret;
    logic [3:0]  b_instret;
    logic [8:0]  a_strb, b_strb;

    int n_asserts = 0;
    int n_fail    = 0;

    assign a_strb = {a_rstrb, a_wstrb, a_asel, a_iwe, a_rfrd, a_alst, a_rfwe, a_pcwe, a_halted};
    assign b_strb = {b_rstrb, b_wstrb, b_asel, b_iwe, b_rfrd, b_alst, b_rfwe, b_pcwe, b_halted};

    always #5 clk = ~clk;

    core_ctrl_fsm dut_a (
        .clk(clk), .reset(rst_a), .instr(instr),
        .mem_rbusy(rbusy), .mem_wbusy(wbusy), .alu_busy(abusy),
        .mem_rstrb(a_rstrb), .mem_wstrb(a_wstrb), .mem_addr_sel(a_asel),
        .instr_we(a_iwe), .rf_rd_en(a_rfrd), .alu_start(a_alst),
        .rf_we(a_rfwe), .pc_we(a_pcwe), .halted(a_halted),
        .illegal(a_illegal), .timeout(a_timeout), .state(a_state), .instret(a_instret)
    );

    core_ctrl_fsm #(.CNT_W(4), .WAIT_LIMIT(4)) dut_b (
        .clk(clk), .reset(rst_b), .instr(instr),
        .mem_rbusy(rbusy), .mem_wbusy(wbusy), .alu_busy(abusy),
        .mem_rstrb(b_rstrb), .mem_wstrb(b_wstrb), .mem_addr_sel(b_asel),
        .instr_we(b_iwe), .rf_rd_en(b_rfrd), .alu_start(b_alst),
        .rf_we(b_rfwe), .pc_we(b_pcwe), .halted(b_halted),
        .illegal(b_illegal), .timeout(b_timeout), .state(b_state), .instret(b_instret)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs mid-cycle, then check state and strobes of the selected DUT.
    task automatic cyc(input bit sel, input logic [31:0] ins, input logic rb, input logic wb,
                       input logic ab, input logic [2:0] st, input logic [8:0] sb, input string tag);
        @(negedge clk);
        instr = ins;
        rbusy = rb;
        wbusy = wb;
        abusy = ab;
        #1;
        check({tag, ".state"}, 32'(sel ? b_state : a_state), 32'(st));
        check({tag, ".strb"},  32'(sel ? b_strb : a_strb),   32'(sb));
    endtask

    task automatic fetch3(input bit sel, input logic [31:0] ins, input string tag);
        cyc(sel, ins, 1'b0, 1'b0, 1'b0, 3'd0, S_RSTB, {tag, ".fetch"});
        cyc(sel, ins, 1'b0, 1'b0, 1'b0, 3'd1, S_IWE,  {tag, ".winstr"});
        cyc(sel, ins, 1'b0, 1'b0, 1'b0, 3'd2, S_RFRD, {tag, ".regs"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, strobes forced low while reset is high
        repeat (2) @(negedge clk);
        #1;
        check("rst.state",   32'(a_state),   32'd0);
        check("rst.strb",    32'(a_strb),    32'(S_NONE));
        check("rst.instret", a_instret,      32'd0);
        check("rst.illegal", 32'(a_illegal), 32'd0);
        check("rst.timeout", 32'(a_timeout), 32'd0);
        @(posedge clk);
        #1 rst_a = 1'b0;

        // ADD x1,x2,x3: 4 cycles
        fetch3(0, I_ADD, "add");
        cyc(0, I_ADD, 1'b0, 1'b0, 1'b0, 3'd3, S_RFWE | S_PCWE, "add.exec");
        $display("ADD retired");

        // SLLI x5,x5,3 with alu_busy high 6 cycles
        fetch3(0, I_SLLI, "slli");
        check("add.instret", a_instret, 32'd1);
        cyc(0, I_SLLI, 1'b0, 1'b0, 1'b0, 3'd3, S_ALST, "slli.exec");
        for (int i = 0; i < 6; i++) cyc(0, I_SLLI, 1'b0, 1'b0, 1'b1, 3'd4, S_NONE, "slli.busy");
        cyc(0, I_SLLI, 1'b0, 1'b0, 1'b0, 3'd4, S_RFWE | S_PCWE, "slli.done");
        $display("SLLI retired");

        // LW x4,0(x2) with mem_rbusy high 3 cycles
        fetch3(0, I_LW, "lw");
        check("slli.instret", a_instret, 32'd2);
        cyc(0, I_LW, 1'b0, 1'b0, 1'b0, 3'd3, S_RSTB | S_ASEL, "lw.exec");
        for (int i = 0; i < 3; i++) cyc(0, I_LW, 1'b1, 1'b0, 1'b0, 3'd5, S_ASEL, "lw.busy");
        cyc(0, I_LW, 1'b0, 1'b0, 1'b0, 3'd5, S_ASEL | S_RFWE | S_PCWE, "lw.done");
        $display("LW retired");

        // SW with mem_wbusy high 2 cycles
        fetch3(0, I_SW, "sw");
        check("lw.instret", a_instret, 32'd3);
        cyc(0, I_SW, 1'b0, 1'b0, 1'b0, 3'd3, S_WSTB | S_ASEL, "sw.exec");
        for (int i = 0; i < 2; i++) cyc(0, I_SW, 1'b0, 1'b1, 1'b0, 3'd6, S_ASEL, "sw.busy");
        cyc(0, I_SW, 1'b0, 1'b0, 1'b0, 3'd6, S_ASEL | S_PCWE, "sw.done");
        $display("SW retired");

        // ADDI x0,x0,1: retires without rf_we
        fetch3(0, I_ADDI0, "addi0");
        check("sw.instret", a_instret, 32'd4);
        cyc(0, I_ADDI0, 1'b0, 1'b0, 1'b0, 3'd3, S_PCWE, "addi0.exec");
        $display("ADDI x0 retired");

        // Reset asserted mid-cycle in WAIT_ALU, exactly when the shifter would finish
        fetch3(0, I_SLLI, "abort");
        check("addi0.instret", a_instret, 32'd5);
        cyc(0, I_SLLI, 1'b0, 1'b0, 1'b0, 3'd3, S_ALST, "abort.exec");
        cyc(0, I_SLLI, 1'b0, 1'b0, 1'b1, 3'd4, S_NONE, "abort.busy");
        check("abort.instret_before", a_instret, 32'd5);
        abusy = 1'b0;
        rst_a = 1'b1;
        #1;
        check("abort.state",   32'(a_state), 32'd0);
        check("abort.strb",    32'(a_strb),  32'(S_NONE));
        check("abort.instret", a_instret,    32'd0);
        @(posedge clk);
        #1;
        check("abort.strb_hold", 32'(a_strb), 32'(S_NONE));
        rst_a = 1'b0;
        $display("Reset during WAIT_ALU");

        // All-zero word is illegal
        fetch3(0, I_ZERO, "ill");
        cyc(0, I_ZERO, 1'b0, 1'b0, 1'b0, 3'd3, S_NONE, "ill.exec");
        cyc(0, I_ZERO, 1'b0, 1'b0, 1'b0, 3'd7, S_HALT, "ill.halt");
        check("ill.illegal", 32'(a_illegal), 32'd1);
        check("ill.timeout", 32'(a_timeout), 32'd0);
        check("ill.instret", a_instret,      32'd0);
        cyc(0, I_ADD, 1'b0, 1'b0, 1'b0, 3'd7, S_HALT, "ill.absorb");
        $display("Illegal halt");

        // SYSTEM halts without illegal
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("ecall.rst_illegal", 32'(a_illegal), 32'd0);
        check("ecall.rst_state",   32'(a_state),   32'd0);
        @(posedge clk);
        #1 rst_a = 1'b0;
        fetch3(0, I_ECALL, "ecall");
        cyc(0, I_ECALL, 1'b0, 1'b0, 1'b0, 3'd3, S_NONE, "ecall.exec");
        cyc(0, I_ECALL, 1'b0, 1'b0, 1'b0, 3'd7, S_HALT, "ecall.halt");
        check("ecall.illegal", 32'(a_illegal), 32'd0);
        $display("SYSTEM halt");
        rst_a = 1'b1;

        // WAIT_LIMIT=4: instruction fetch stuck busy
        @(posedge clk);
        #1 rst_b = 1'b0;
        cyc(1, I_ADD, 1'b0, 1'b0, 1'b0, 3'd0, S_RSTB, "to.fetch");
        for (int i = 0; i < 4; i++) cyc(1, I_ADD, 1'b1, 1'b0, 1'b0, 3'd1, S_NONE, "to.wait");
        cyc(1, I_ADD, 1'b1, 1'b0, 1'b0, 3'd7, S_HALT, "to.halt");
        check("to.timeout", 32'(b_timeout), 32'd1);
        check("to.illegal", 32'(b_illegal), 32'd0);
        check("to.instret", 32'(b_instret), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("to.rst_timeout", 32'(b_timeout), 32'd0);
        check("to.rst_state",   32'(b_state),   32'd0);
        @(posedge clk);
        #1 rst_b = 1'b0;
        $display("Wait-limit timeout");

        // Busy one cycle short of the limit does not time out; then 17 retirements on a 4-bit counter
        cyc(1, I_ADD, 1'b0, 1'b0, 1'b0, 3'd0, S_RSTB, "near.fetch");
        for (int i = 0; i < 3; i++) cyc(1, I_ADD, 1'b1, 1'b0, 1'b0, 3'd1, S_NONE, "near.wait");
        cyc(1, I_ADD, 1'b0, 1'b0, 1'b0, 3'd1, S_IWE,  "near.iwe");
        cyc(1, I_ADD, 1'b0, 1'b0, 1'b0, 3'd2, S_RFRD, "near.regs");
        cyc(1, I_ADD, 1'b0, 1'b0, 1'b0, 3'd3, S_RFWE | S_PCWE, "near.exec");
        for (int i = 0; i < 16; i++) begin
            fetch3(1, I_ADD, "wrap");
            cyc(1, I_ADD, 1'b0, 1'b0, 1'b0, 3'd3, S_RFWE | S_PCWE, "wrap.exec");
        end
        @(negedge clk);
        #1;
        check("wrap.instret", 32'(b_instret), 32'd1);
        check("wrap.timeout", 32'(b_timeout), 32'd0);
        $display("17 retirements on 4-bit instret");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
